// File: rtl/hdmi_frame_reader.sv
// Framebuffer read scheduler: paces memory read bursts into the line FIFO,
// restarting the frame address on every falling edge of the field sync.
module hdmi_frame_reader #(
  parameter int          H_DISP     = 800,
  parameter int          V_DISP     = 600,
  parameter int          BURST_LEN  = 64,
  parameter int          FIFO_DEPTH = 1024,
  parameter logic [23:0] FB_BASE    = 24'h000000
) (
  input  logic        pixel_clk,
  input  logic        sys_rst,
  input  logic        enable,
  input  logic        video_vs,
  input  logic [10:0] fifo_level,
  output logic        rd_req,
  output logic [23:0] rd_addr,
  output logic [7:0]  rd_len,
  input  logic        rd_ack,
  input  logic        rd_valid,
  input  logic        rd_done,
  output logic        frame_start,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE, WAIT_FRAME, CHECK, REQ, XFER
  } state_t;

  localparam logic [19:0] FRAME_WORDS = 20'(H_DISP * V_DISP);
  localparam logic [19:0] BURST_W     = 20'(BURST_LEN);
  localparam logic [7:0]  BURST_8     = 8'(BURST_LEN);
  localparam logic [11:0] DEPTH       = 12'(FIFO_DEPTH);

  state_t      state_q, state_d;
  logic [23:0] addr_q, addr_d;
  logic [19:0] remain_q, remain_d;
  logic [8:0]  beat_q, beat_d;
  logic        pend_q, pend_d;
  logic        vs_prev_q, vs_prev_d;
  logic        rd_req_q, rd_req_d;
  logic [23:0] rd_addr_q, rd_addr_d;
  logic [7:0]  rd_len_q, rd_len_d;
  logic        frame_start_q, frame_start_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;

  logic        vs_fall;
  logic [7:0]  len;
  logic        fits;
  logic [8:0]  beats_end;
  logic        restart;

  always_comb begin
    vs_fall   = vs_prev_q & ~video_vs;
    len       = (remain_q < BURST_W) ? remain_q[7:0] : BURST_8;
    fits      = ({1'b0, fifo_level} + {4'b0, len}) <= DEPTH;
    beats_end = beat_q + {8'b0, rd_valid};
    restart   = 1'b0;

    state_d       = state_q;
    addr_d        = addr_q;
    remain_d      = remain_q;
    beat_d        = beat_q;
    pend_d        = pend_q;
    vs_prev_d     = video_vs;
    rd_req_d      = rd_req_q;
    rd_addr_d     = rd_addr_q;
    rd_len_d      = rd_len_q;
    frame_start_d = 1'b0;
    err_d         = err_q;

    // Data-path strobes are only legal while a burst is in flight
    if (state_q != XFER && (rd_valid || rd_done))
      err_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        rd_req_d = 1'b0;
        if (enable)
          state_d = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        if (!enable)
          state_d = IDLE;
        else if (vs_fall)
          restart = 1'b1;
      end
      CHECK: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (vs_fall) begin
          restart = 1'b1;
        end else if (remain_q == 20'd0) begin
          state_d = WAIT_FRAME;
        end else if (fits) begin
          rd_addr_d = addr_q;
          rd_len_d  = len;
          rd_req_d  = 1'b1;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (!enable) begin
          rd_req_d = 1'b0;
          state_d  = IDLE;
        end else if (rd_ack) begin
          // An accepted burst must drain; a coincident sync waits for it
          rd_req_d = 1'b0;
          beat_d   = 9'd0;
          pend_d   = vs_fall;
          state_d  = XFER;
        end else if (vs_fall) begin
          rd_req_d = 1'b0;
          restart  = 1'b1;
        end
      end
      XFER: begin
        pend_d = pend_q | vs_fall;
        beat_d = beats_end;
        if (rd_done) begin
          if (beats_end != {1'b0, rd_len_q})
            err_d = 1'b1;
          addr_d   = addr_q + {16'b0, rd_len_q};
          remain_d = remain_q - {12'b0, rd_len_q};
          pend_d   = 1'b0;
          if (!enable)
            state_d = IDLE;
          else if (pend_q || vs_fall)
            restart = 1'b1;
          else
            state_d = CHECK;
        end
      end
      default: state_d = IDLE;
    endcase

    if (restart) begin
      frame_start_d = 1'b1;
      addr_d        = FB_BASE;
      remain_d      = FRAME_WORDS;
      state_d       = CHECK;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q       <= IDLE;
      addr_q        <= 24'd0;
      remain_q      <= 20'd0;
      beat_q        <= 9'd0;
      pend_q        <= 1'b0;
      vs_prev_q     <= 1'b1;
      rd_req_q      <= 1'b0;
      rd_addr_q     <= 24'd0;
      rd_len_q      <= 8'd0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      remain_q      <= remain_d;
      beat_q        <= beat_d;
      pend_q        <= pend_d;
      vs_prev_q     <= vs_prev_d;
      rd_req_q      <= rd_req_d;
      rd_addr_q     <= rd_addr_d;
      rd_len_q      <= rd_len_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
    end
  end

  assign rd_req      = rd_req_q;
  assign rd_addr     = rd_addr_q;
  assign rd_len      = rd_len_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;
  assign err         = err_q;

endmodule

// File: tb/tb_hdmi_frame_reader.sv
// Directed bench for hdmi_frame_reader: default-size, 10x10 and 32x20
// instances share stimulus; a behavioural arbiter serves the selected one.
module tb_hdmi_frame_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vs = 1'b1;
  logic [10:0] lvl = 11'd0;
  logic        ack = 1'b0;
  logic        vld = 1'b0;
  logic        dn = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic [2:0]  en = 3'b000;

  logic [2:0]  ack_v, vld_v, dn_v;
  logic [2:0]  rq, fs, bz, er;
  logic [23:0] ad [3];
  logic [7:0]  ln [3];

  int n_cmp = 0;
  int n_bad = 0;
  int fs_cnt2 = 0;

  always #5 clk = ~clk;

  assign ack_v = ack ? (3'b001 << sel) : 3'b000;
  assign vld_v = vld ? (3'b001 << sel) : 3'b000;
  assign dn_v  = dn  ? (3'b001 << sel) : 3'b000;

  hdmi_frame_reader u0 (
    .pixel_clk(clk), .sys_rst(rst), .enable(en[0]),
    .video_vs(vs), .fifo_level(lvl),
    .rd_req(rq[0]), .rd_addr(ad[0]), .rd_len(ln[0]),
    .rd_ack(ack_v[0]), .rd_valid(vld_v[0]), .rd_done(dn_v[0]),
    .frame_start(fs[0]), .busy(bz[0]), .err(er[0])
  );

  hdmi_frame_reader #(.H_DISP(10), .V_DISP(10)) u1 (
    .pixel_clk(clk), .sys_rst(rst), .enable(en[1]),
    .video_vs(vs), .fifo_level(lvl),
    .rd_req(rq[1]), .rd_addr(ad[1]), .rd_len(ln[1]),
    .rd_ack(ack_v[1]), .rd_valid(vld_v[1]), .rd_done(dn_v[1]),
    .frame_start(fs[1]), .busy(bz[1]), .err(er[1])
  );

  hdmi_frame_reader #(.H_DISP(32), .V_DISP(20)) u2 (
    .pixel_clk(clk), .sys_rst(rst), .enable(en[2]),
    .video_vs(vs), .fifo_level(lvl),
    .rd_req(rq[2]), .rd_addr(ad[2]), .rd_len(ln[2]),
    .rd_ack(ack_v[2]), .rd_valid(vld_v[2]), .rd_done(dn_v[2]),
    .frame_start(fs[2]), .busy(bz[2]), .err(er[2])
  );

  always @(negedge clk) if (fs[2]) fs_cnt2++;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 100 && !rq[sel]; i++) cyc();
    chk("req_seen", 32'(rq[sel]), 1);
  endtask

  // Arbiter: ack two cycles after the request, then nb beats, last with done
  task automatic run_burst(input logic [23:0] ea, input logic [7:0] el,
                           input int nb, input int vs_at);
    wait_req();
    chk("burst_addr", 32'(ad[sel]), 32'(ea));
    chk("burst_len", 32'(ln[sel]), 32'(el));
    cyc(2);
    chk("req_held", 32'(rq[sel]), 1);
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    chk("req_drop_after_ack", 32'(rq[sel]), 0);
    for (int b = 0; b < nb; b++) begin
      vld = 1'b1;
      dn  = (b == nb - 1);
      if (b == vs_at) vs = 1'b0;
      if (b == vs_at + 1) vs = 1'b1;
      cyc();
    end
    vld = 1'b0;
    dn  = 1'b0;
    vs  = 1'b1;
  endtask

  task automatic frame_edge();
    vs = 1'b0;
    cyc();
    vs = 1'b1;
  endtask

  initial begin
    // Reset state
    cyc(2);
    chk("rst_rd_req", 32'(rq[0]), 0);
    chk("rst_rd_addr", 32'(ad[0]), 0);
    chk("rst_rd_len", 32'(ln[0]), 0);
    chk("rst_busy", 32'(bz[0]), 0);
    chk("rst_err", 32'(er[0]), 0);
    rst = 1'b0;
    cyc();

    // Back-pressure on the default-size instance
    sel = 2'd0;
    lvl = 11'd961;
    en[0] = 1'b1;
    cyc();
    chk("busy_wait_frame", 32'(bz[0]), 1);
    chk("no_fs_before_vs", 32'(fs[0]), 0);
    vs = 1'b0;
    cyc();
    chk("fs_pulse", 32'(fs[0]), 1);
    chk("check_no_req", 32'(rq[0]), 0);
    vs = 1'b1;
    cyc();
    chk("fs_one_cycle", 32'(fs[0]), 0);
    cyc(4);
    chk("bp_hold_961", 32'(rq[0]), 0);
    lvl = 11'd960;
    cyc();
    chk("bp_req_960", 32'(rq[0]), 1);
    chk("bp_len_960", 32'(ln[0]), 64);
    run_burst(24'd0, 8'd64, 64, -1);
    wait_req();
    chk("second_addr", 32'(ad[0]), 64);

    // Sync while requesting: immediate restart
    frame_edge();
    chk("req_vs_drop", 32'(rq[0]), 0);
    chk("req_vs_fs", 32'(fs[0]), 1);
    // Sync mid-transfer: burst completes, then restart at the base
    run_burst(24'd0, 8'd64, 64, 10);
    chk("xfer_vs_fs", 32'(fs[0]), 1);
    wait_req();
    chk("xfer_vs_base", 32'(ad[0]), 0);
    chk("no_err_yet", 32'(er[0]), 0);

    // Enable dropped in XFER: burst still drains before IDLE
    cyc(2);
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    en[0] = 1'b0;
    vld = 1'b1;
    cyc(10);
    chk("stop_busy_xfer", 32'(bz[0]), 1);
    cyc(53);
    dn = 1'b1;
    cyc();
    vld = 1'b0;
    dn = 1'b0;
    chk("stop_idle", 32'(bz[0]), 0);
    chk("stop_no_err", 32'(er[0]), 0);

    // Beat-count mismatch: sticky error
    en[0] = 1'b1;
    cyc();
    frame_edge();
    run_burst(24'd0, 8'd64, 63, -1);
    chk("mismatch_err", 32'(er[0]), 1);
    wait_req();
    chk("mismatch_next_addr", 32'(ad[0]), 64);
    en[0] = 1'b0;
    cyc();
    chk("disable_req_drop", 32'(rq[0]), 0);
    chk("disable_idle", 32'(bz[0]), 0);
    chk("err_sticky", 32'(er[0]), 1);

    // Reset mid-REQ
    en[0] = 1'b1;
    cyc();
    frame_edge();
    cyc();
    chk("pre_rst_req", 32'(rq[0]), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_req", 32'(rq[0]), 0);
    chk("async_rst_err", 32'(er[0]), 0);
    chk("async_rst_fs", 32'(fs[0]), 0);
    en[0] = 1'b0;
    cyc();
    rst = 1'b0;
    cyc(3);
    chk("post_rst_idle", 32'(bz[0]), 0);
    en[0] = 1'b1;
    cyc();
    chk("post_rst_enable", 32'(bz[0]), 1);

    // Stray beat outside a transfer
    vld = 1'b1;
    cyc();
    vld = 1'b0;
    chk("stray_beat_err", 32'(er[0]), 1);
    en[0] = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();

    // 10x10 frame: 64-word burst then a 36-word tail
    sel = 2'd1;
    lvl = 11'd0;
    en[1] = 1'b1;
    cyc();
    frame_edge();
    run_burst(24'd0, 8'd64, 64, -1);
    run_burst(24'd64, 8'd36, 36, -1);
    cyc(5);
    chk("short_wait_no_req", 32'(rq[1]), 0);
    chk("short_wait_busy", 32'(bz[1]), 1);
    chk("short_no_err", 32'(er[1]), 0);
    vs = 1'b0;
    cyc();
    vs = 1'b1;
    chk("short_next_fs", 32'(fs[1]), 1);
    en[1] = 1'b0;
    cyc(2);

    // 32x20 frame end to end: ten bursts, one frame_start
    sel = 2'd2;
    en[2] = 1'b1;
    cyc();
    frame_edge();
    for (int i = 0; i < 10; i++)
      run_burst(24'(i * 64), 8'd64, 64, -1);
    cyc(5);
    chk("frame_done_no_req", 32'(rq[2]), 0);
    chk("frame_done_busy", 32'(bz[2]), 1);
    chk("frame_fs_count", 32'(fs_cnt2), 1);
    chk("frame_no_err", 32'(er[2]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
